// File: rtl/pc_ctrl.sv
// rtl/pc_ctrl.sv - program counter with trap/return/jump/branch redirect and circular return-address stack
module pc_ctrl #(
    parameter int                WIDTH       = 32,
    parameter logic [WIDTH-1:0]  RESET_VEC   = '0,
    parameter logic [WIDTH-1:0]  TRAP_VEC    = 'h80,
    parameter int                INSTR_BYTES = 4,
    parameter int                RAS_DEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             call,
    input  logic             jr,
    input  logic [WIDTH-1:0] jr_target,
    input  logic             ret,
    input  logic             trap,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] npc,
    output logic [WIDTH-1:0] epc,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_ovf,
    output logic             ras_unf
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] pc_q, pc_d, epc_q, epc_d;
    logic [PW-1:0]    top_q, top_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             wr_en;
    logic [PW-1:0]    wr_ptr;
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

    assign npc       = pc_q + WIDTH'(INSTR_BYTES);
    assign pc        = pc_q;
    assign epc       = epc_q;
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CW'(RAS_DEPTH));
    assign ras_ovf   = ovf_q;
    assign ras_unf   = unf_q;

    always_comb begin
        pc_d   = pc_q;
        epc_d  = epc_q;
        top_d  = top_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        wr_en  = 1'b0;
        wr_ptr = top_q;
        if (trap) begin
            pc_d  = TRAP_VEC;
            epc_d = pc_q;
        end else if (!stall) begin
            if (ret) begin
                if (call && jump) begin
                    // ret wins the redirect while the call replaces the top entry in place
                    wr_en = 1'b1;
                    if (ras_empty) begin
                        pc_d  = jr_target;
                        cnt_d = CW'(1);
                        unf_d = 1'b1;
                    end else begin
                        pc_d = ras_mem[top_q];
                    end
                end else if (ras_empty) begin
                    pc_d  = jr_target;
                    unf_d = 1'b1;
                end else begin
                    pc_d  = ras_mem[top_q];
                    top_d = top_q - PW'(1);
                    cnt_d = cnt_q - CW'(1);
                end
            end else if (jr) begin
                pc_d = jr_target;
            end else if (jump) begin
                pc_d = jump_target;
                if (call) begin
                    wr_en  = 1'b1;
                    wr_ptr = top_q + PW'(1);
                    top_d  = top_q + PW'(1);
                    if (ras_full) ovf_d = 1'b1;
                    else          cnt_d = cnt_q + CW'(1);
                end
            end else if (br_taken) begin
                pc_d = br_target;
            end else begin
                pc_d = npc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q  <= RESET_VEC;
            epc_q <= '0;
            top_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
            top_q <= top_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Entries are never cleared; an empty count keeps stale contents unreachable.
    always_ff @(posedge clk) begin
        if (rst && wr_en) ras_mem[wr_ptr] <= npc;
    end
endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: width of the PC and of all address ports.
REQ-002 Parameter RESET_VEC, default 0: PC value loaded on reset.
REQ-003 Parameter TRAP_VEC, default 32'h0000_0080: PC value loaded on trap.
REQ-004 Parameter INSTR_BYTES, default 4: sequential increment.
REQ-005 Parameter RAS_DEPTH, default 4: return-address-stack entries (power of 2, >=2).
REQ-006 Port clk, input, 1: clock, all state updates on rising edge.
REQ-007 Port rst, input, 1: asynchronous, active-low reset.
REQ-008 Port stall, input, 1: hold PC and RAS this cycle.
REQ-009 Port br_taken, input, 1; port br_target, input, WIDTH: conditional branch redirect.
REQ-010 Port jump, input, 1; port jump_target, input, WIDTH: direct jump.
REQ-011 Port call, input, 1: qualifies jump as a call (push return address).
REQ-012 Port jr, input, 1; port jr_target, input, WIDTH: register-indirect jump, also fallback for ret.
REQ-013 Port ret, input, 1: return (pop RAS, redirect to popped value).
REQ-014 Port trap, input, 1: exception redirect.
REQ-015 Port pc, output, WIDTH: current PC (registered).
REQ-016 Port npc, output, WIDTH: pc + INSTR_BYTES (combinational).
REQ-017 Port epc, output, WIDTH: PC captured at last trap (registered).
REQ-018 Ports ras_empty, ras_full, output, 1 each: RAS occupancy flags.
REQ-019 Ports ras_ovf, ras_unf, output, 1 each: sticky overflow/underflow flags.

Function
REQ-020 Next PC priority, highest first: trap, ret, jr, jump, br_taken, sequential (npc).
REQ-021 trap SHALL load pc<=TRAP_VEC and epc<=pc, ignore all other requests and stall, leave RAS unchanged.
REQ-022 stall without trap SHALL hold pc, epc and RAS; all other requests ignored that cycle.
REQ-023 call SHALL only take effect when jump is the winning redirect; call without jump is ignored.
REQ-024 call push: RAS top<=npc, count+1; 1-cycle latency, entry visible to a ret on the next cycle.
REQ-025 Push when full: overwrite oldest entry (circular), count stays RAS_DEPTH, set ras_ovf.
REQ-026 ret with count>0: pc<=top entry, count-1.
REQ-027 ret with count==0: pc<=jr_target, count stays 0, set ras_unf.
REQ-028 ret and call asserted together (jump also asserted): pc<=top entry (ret wins), top entry replaced by npc, count unchanged; if empty, count becomes 1 and ras_unf set.
REQ-029 ras_empty = (count==0); ras_full = (count==RAS_DEPTH); both combinational from registered count.
REQ-030 ras_ovf and ras_unf SHALL remain set until reset.
REQ-031 All PC arithmetic modulo 2^WIDTH; npc at pc = 2^WIDTH-INSTR_BYTES SHALL wrap to 0.
REQ-032 Targets SHALL be loaded unmodified (no alignment masking).

Reset
REQ-033 On rst low, immediately and independent of clk: pc=RESET_VEC, epc=0, count=0, ras_empty=1, ras_full=0, ras_ovf=0, ras_unf=0.
REQ-034 RAS entry contents need not be cleared; they SHALL be unobservable while count==0.
REQ-035 Reset asserted mid-cycle SHALL abort any pending push/pop; first update after release occurs on the first rising clk with rst high.

Verification
REQ-036 Reset release, no requests, 3 clocks -> pc 0, 4, 8, 12; npc always pc+4.
REQ-037 pc=0x100, jump+call to 0x200; next cycle ret -> pc 0x200 then 0x104; ras_empty 1 again, flags clear.
REQ-038 Five call+jump pushes with RAS_DEPTH=4 from pc 0x10,0x20,0x30,0x40,0x50 -> ras_full 1, ras_ovf 1; four rets return 0x54,0x44,0x34,0x24; fifth ret goes to jr_target, ras_unf 1.
REQ-039 pc=0x40, trap with stall, jump, ret all high -> pc=0x80, epc=0x40, RAS count unchanged.
REQ-040 stall high 2 cycles with br_taken to 0x300 -> pc held; stall low with br_taken -> pc 0x300.
REQ-041 pc=0xFFFF_FFFC, no requests -> pc 0; rst low asynchronously mid-cycle -> pc 0 before next edge.
